// File: rtl/d5m_pattern_gen_if.sv
// Control and pixel-bus bundle of the synthetic D5M source.
// The master side is the generator; the slave side is the capture logic or a bench.
interface d5m_pattern_gen_if;
    logic        iSTART;
    logic        iEND;
    logic [1:0]  iMODE;
    logic [11:0] oDATA;
    logic        oLVAL;
    logic        oFVAL;
    logic [31:0] oFrame_Cont;
    logic        oBUSY;

    modport master (
        input  iSTART,
        input  iEND,
        input  iMODE,
        output oDATA,
        output oLVAL,
        output oFVAL,
        output oFrame_Cont,
        output oBUSY
    );

    modport slave (
        output iSTART,
        output iEND,
        output iMODE,
        input  oDATA,
        input  oLVAL,
        input  oFVAL,
        input  oFrame_Cont,
        input  oBUSY
    );
endinterface

// File: rtl/d5m_pattern_gen.sv
// Synthetic D5M sensor: 12-bit raw Bayer stream with FVAL/LVAL framing,
// run/stop control, four test patterns and a completed-frame counter.
module d5m_pattern_gen #(
    parameter int H_ACTIVE = 1280,
    parameter int V_ACTIVE = 960,
    parameter int H_BLANK  = 64,
    parameter int V_BLANK  = 2048
) (
    input  logic               iCLK,
    input  logic               iRST_N,
    d5m_pattern_gen_if.master  bus
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LEAD,
        S_ACTIVE,
        S_HBLANK,
        S_VBLANK
    } state_t;

    localparam logic [11:0] X_LAST  = 12'(H_ACTIVE - 1);
    localparam logic [11:0] Y_LAST  = 12'(V_ACTIVE - 1);
    localparam logic [15:0] HB_LAST = 16'(H_BLANK - 1);
    localparam logic [15:0] VB_LAST = 16'(V_BLANK - 1);

    state_t      state_q, state_d;
    logic [11:0] x_q, x_d;
    logic [11:0] y_q, y_d;
    logic [15:0] cnt_q, cnt_d;
    logic [1:0]  mode_q, mode_d;
    logic        stop_q, stop_d;
    logic [31:0] frame_q, frame_d;

    // Inputs are registered once so no input reaches an output combinationally.
    logic        start_q;
    logic        end_q;
    logic [1:0]  imode_q;

    logic [11:0] data_q, data_d;
    logic        lval_q, lval_d;
    logic        fval_q, fval_d;
    logic        busy_q, busy_d;

    function automatic logic [11:0] pixel(input logic [1:0] m,
                                          input logic [11:0] x,
                                          input logic [11:0] y);
        logic [2:0] b;
        logic       on;
        b  = x[9:7];
        on = 1'b0;
        case (m)
            2'd0: begin
                case ({y[0], x[0]})
                    2'b01:   on = b[2];
                    2'b10:   on = b[0];
                    default: on = b[1];
                endcase
                pixel = {12{on}};
            end
            2'd1:    pixel = x;
            2'd2:    pixel = (x[4] ^ y[4]) ? 12'hFFF : 12'h000;
            default: pixel = y;
        endcase
    endfunction

    always_comb begin
        state_d = state_q;
        x_d     = x_q;
        y_d     = y_q;
        cnt_d   = cnt_q;
        mode_d  = mode_q;
        frame_d = frame_q;
        stop_d  = stop_q;

        if (end_q) begin
            stop_d = 1'b1;
        end else if (start_q) begin
            stop_d = 1'b0;
        end

        case (state_q)
            S_IDLE: begin
                if (start_q && !end_q) begin
                    state_d = S_LEAD;
                    cnt_d   = 16'd0;
                    mode_d  = imode_q;
                end
            end
            S_LEAD: begin
                if (cnt_q == HB_LAST) begin
                    state_d = S_ACTIVE;
                    x_d     = 12'd0;
                    y_d     = 12'd0;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            S_ACTIVE: begin
                if (x_q == X_LAST) begin
                    state_d = S_HBLANK;
                    cnt_d   = 16'd0;
                end else begin
                    x_d = x_q + 12'd1;
                end
            end
            S_HBLANK: begin
                if (cnt_q == HB_LAST) begin
                    if (y_q != Y_LAST) begin
                        state_d = S_ACTIVE;
                        x_d     = 12'd0;
                        y_d     = y_q + 12'd1;
                    end else begin
                        state_d = S_VBLANK;
                        cnt_d   = 16'd0;
                        frame_d = frame_q + 32'd1;
                    end
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            S_VBLANK: begin
                if (cnt_q == VB_LAST) begin
                    if (stop_q) begin
                        state_d = S_IDLE;
                        stop_d  = 1'b0;
                    end else begin
                        state_d = S_LEAD;
                        cnt_d   = 16'd0;
                        mode_d  = imode_q;
                    end
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            default: begin
                state_d = S_IDLE;
                stop_d  = 1'b0;
            end
        endcase

        // Outputs are decoded from the next state so they register on the transition edge.
        lval_d = (state_d == S_ACTIVE);
        fval_d = (state_d == S_LEAD) || (state_d == S_ACTIVE) || (state_d == S_HBLANK);
        busy_d = (state_d != S_IDLE);
        data_d = lval_d ? pixel(mode_d, x_d, y_d) : 12'h000;
    end

    always_ff @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N) begin
            state_q <= S_IDLE;
            x_q     <= 12'd0;
            y_q     <= 12'd0;
            cnt_q   <= 16'd0;
            mode_q  <= 2'd0;
            stop_q  <= 1'b0;
            frame_q <= 32'd0;
            start_q <= 1'b0;
            end_q   <= 1'b0;
            imode_q <= 2'd0;
            data_q  <= 12'h000;
            lval_q  <= 1'b0;
            fval_q  <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            x_q     <= x_d;
            y_q     <= y_d;
            cnt_q   <= cnt_d;
            mode_q  <= mode_d;
            stop_q  <= stop_d;
            frame_q <= frame_d;
            start_q <= bus.iSTART;
            end_q   <= bus.iEND;
            imode_q <= bus.iMODE;
            data_q  <= data_d;
            lval_q  <= lval_d;
            fval_q  <= fval_d;
            busy_q  <= busy_d;
        end
    end

    assign bus.oDATA       = data_q;
    assign bus.oLVAL       = lval_q;
    assign bus.oFVAL       = fval_q;
    assign bus.oFrame_Cont = frame_q;
    assign bus.oBUSY       = busy_q;

endmodule
